// File: rtl/mem_rs_queue.sv
// In-order memory reservation queue: loads/stores allocate at the tail, stores
// snoop the CDB for their data, and only the head entry may issue.
module mem_rs_queue #(
    parameter int DEPTH  = 4,
    parameter int ROB_W  = 2,
    parameter int DATA_W = 3,
    parameter int ADDR_W = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       write_en,
    input  logic [ROB_W-1:0]           rob_idx,
    input  logic [2:0]                 opcode,
    input  logic [DATA_W-1:0]          val,
    input  logic [ROB_W-1:0]           q_val,
    input  logic                       val_ready,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       cdb_en,
    input  logic [ROB_W-1:0]           cdb_rob_idx,
    input  logic [DATA_W-1:0]          cdb_val,
    input  logic                       exec_ready,
    output logic                       exec_valid,
    output logic [2:0]                 exec_opcode,
    output logic [DATA_W-1:0]          exec_val,
    output logic [ADDR_W-1:0]          exec_addr,
    output logic [ROB_W-1:0]           exec_rob_idx,
    output logic                       rs_full,
    output logic                       rs_empty,
    output logic [$clog2(DEPTH+1)-1:0] rs_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [2:0] OP_LD  = 3'b101;
    localparam logic [2:0] OP_STR = 3'b110;

    typedef struct packed {
        logic              rdy;
        logic [2:0]        op;
        logic [DATA_W-1:0] dat;
        logic [ROB_W-1:0]  qv;
        logic [ADDR_W-1:0] addr;
        logic [ROB_W-1:0]  rob;
    } ent_t;

    ent_t          ent_q [DEPTH];
    ent_t          ent_d [DEPTH];
    ent_t          new_ent;
    logic [PW-1:0] head, tail;
    logic          alloc, xfer, byp;
    logic [PW-1:0] off;
    logic          occ;

    assign rs_full      = (rs_count == CW'(DEPTH));
    assign rs_empty     = (rs_count == '0);
    assign exec_valid   = !rs_empty && ent_q[head].rdy;
    assign exec_opcode  = ent_q[head].op;
    assign exec_val     = ent_q[head].dat;
    assign exec_addr    = ent_q[head].addr;
    assign exec_rob_idx = ent_q[head].rob;

    assign alloc = write_en && !rs_full && (opcode == OP_LD || opcode == OP_STR);
    assign xfer  = exec_valid && exec_ready;
    // A store whose producer broadcasts in its allocation cycle captures the data directly.
    assign byp   = (opcode == OP_STR) && !val_ready && cdb_en && (cdb_rob_idx == q_val);

    always_comb begin
        new_ent      = '0;
        new_ent.rdy  = (opcode == OP_LD) || val_ready || byp;
        new_ent.op   = opcode;
        new_ent.dat  = byp ? cdb_val : val;
        new_ent.qv   = q_val;
        new_ent.addr = addr;
        new_ent.rob  = rob_idx;
    end

    always_comb begin
        off = '0;
        occ = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            off = PW'(i) - head;
            occ = CW'(off) < rs_count;
            if (occ && ent_q[i].op == OP_STR && !ent_q[i].rdy && cdb_en &&
                ent_q[i].qv == cdb_rob_idx) begin
                ent_d[i].rdy = 1'b1;
                ent_d[i].dat = cdb_val;
            end
            // The tail slot is never occupied when alloc is set (alloc requires !full).
            if (alloc && PW'(i) == tail)
                ent_d[i] = new_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            rs_count <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            rs_count <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            if (xfer)  head <= head + 1'b1;
            if (alloc) tail <= tail + 1'b1;
            if (alloc && !xfer)      rs_count <= rs_count + 1'b1;
            else if (!alloc && xfer) rs_count <= rs_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_rs_queue.sv
// Directed bench for mem_rs_queue: stimulus pushes expected issues into a
// scoreboard; a negedge monitor pops and compares every handshake.
module tb_mem_rs_queue;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0, write_en = 1'b0, val_ready = 1'b0, cdb_en = 1'b0, exec_ready = 1'b0;
    logic [1:0] rob_idx = '0, q_val = '0, addr = '0, cdb_rob_idx = '0;
    logic [2:0] opcode = '0, val = '0, cdb_val = '0;
    logic       exec_valid, rs_full, rs_empty;
    logic [2:0] exec_opcode, exec_val, rs_count;
    logic [1:0] exec_addr, exec_rob_idx;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] v;
        logic [1:0] a;
        logic [1:0] r;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    localparam logic [2:0] LD = 3'b101, STR = 3'b110;

    mem_rs_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .write_en(write_en),
        .rob_idx(rob_idx), .opcode(opcode), .val(val), .q_val(q_val),
        .val_ready(val_ready), .addr(addr), .cdb_en(cdb_en),
        .cdb_rob_idx(cdb_rob_idx), .cdb_val(cdb_val), .exec_ready(exec_ready),
        .exec_valid(exec_valid), .exec_opcode(exec_opcode), .exec_val(exec_val),
        .exec_addr(exec_addr), .exec_rob_idx(exec_rob_idx), .rs_full(rs_full),
        .rs_empty(rs_empty), .rs_count(rs_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake must match the oldest expected issue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !flush && exec_valid && exec_ready) begin
            if (sb.size() == 0) begin
                chk("issue_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("issue_opcode", int'(exec_opcode), int'(e.op));
                chk("issue_val", int'(exec_val), int'(e.v));
                chk("issue_addr", int'(exec_addr), int'(e.a));
                chk("issue_rob", int'(exec_rob_idx), int'(e.r));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        write_en = 1'b0;
        cdb_en   = 1'b0;
        flush    = 1'b0;
    endtask

    // Present one allocation for the next edge; push the expectation if it should be accepted.
    task automatic wr(input logic [2:0] op, input logic [1:0] rob, input logic [2:0] v,
                      input logic [1:0] qv, input logic vr, input logic [1:0] a,
                      input logic accept, input logic [2:0] exp_v);
        write_en  = 1'b1;
        opcode    = op;
        rob_idx   = rob;
        val       = v;
        q_val     = qv;
        val_ready = vr;
        addr      = a;
        if (accept) sb.push_back('{op: op, v: exp_v, a: a, r: rob});
    endtask

    task automatic cdb(input logic [1:0] tag, input logic [2:0] v);
        cdb_en      = 1'b1;
        cdb_rob_idx = tag;
        cdb_val     = v;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, int'(exec_valid), 0);
        chk({tag, "_opcode"}, int'(exec_opcode), 0);
        chk({tag, "_val"}, int'(exec_val), 0);
        chk({tag, "_addr"}, int'(exec_addr), 0);
        chk({tag, "_rob"}, int'(exec_rob_idx), 0);
        chk({tag, "_empty"}, int'(rs_empty), 1);
        chk({tag, "_full"}, int'(rs_full), 0);
        chk({tag, "_count"}, int'(rs_count), 0);
    endtask

    initial begin
        #3;
        chk_reset_outs("rst");
        #20 rst_n = 1'b1;
        step();

        // Single load issues the cycle after allocation
        exec_ready = 1'b1;
        wr(LD, 2'd1, 3'd0, 2'd0, 1'b0, 2'd2, 1'b1, 3'd0);
        step();
        chk("ld_valid", int'(exec_valid), 1);
        chk("ld_opcode", int'(exec_opcode), 5);
        chk("ld_addr", int'(exec_addr), 2);
        step();
        chk("ld_drained", int'(rs_empty), 1);

        // Waiting store blocks a younger ready load until its CDB tag arrives
        wr(STR, 2'd0, 3'd0, 2'd3, 1'b0, 2'd1, 1'b1, 3'd5);
        step();
        chk("str_wait_valid", int'(exec_valid), 0);
        wr(LD, 2'd1, 3'd0, 2'd0, 1'b0, 2'd3, 1'b1, 3'd0);
        step();
        chk("str_block_valid", int'(exec_valid), 0);
        chk("str_block_count", int'(rs_count), 2);
        cdb(2'd2, 3'd7);
        step();
        chk("str_wrongtag_valid", int'(exec_valid), 0);
        cdb(2'd3, 3'd5);
        step();
        chk("str_wake_valid", int'(exec_valid), 1);
        chk("str_wake_opcode", int'(exec_opcode), 6);
        chk("str_wake_val", int'(exec_val), 5);
        step();
        chk("ld_behind_valid", int'(exec_valid), 1);
        chk("ld_behind_opcode", int'(exec_opcode), 5);
        step();
        chk("str_seq_empty", int'(rs_empty), 1);

        // Fill to full, reject extra writes, simultaneous transfer at full
        exec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr(LD, 2'(i), 3'd0, 2'd0, 1'b0, 2'(3 - i), 1'b1, 3'd0);
            step();
        end
        chk("full_flag", int'(rs_full), 1);
        chk("full_count", int'(rs_count), 4);
        wr(LD, 2'd2, 3'd0, 2'd0, 1'b0, 2'd2, 1'b0, 3'd0);
        step();
        chk("full_reject_count", int'(rs_count), 4);
        wr(STR, 2'd3, 3'd1, 2'd0, 1'b1, 2'd1, 1'b0, 3'd1);
        exec_ready = 1'b1;
        step();
        chk("full_xfer_count", int'(rs_count), 3);
        chk("full_xfer_flag", int'(rs_full), 0);
        wr(3'b011, 2'd0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 3'd0);
        step();
        chk("badop_count", int'(rs_count), 2);
        step();
        step();
        chk("full_drained", int'(rs_empty), 1);

        // Store allocated in the same cycle as its producer's broadcast
        wr(STR, 2'd2, 3'd0, 2'd2, 1'b0, 2'd0, 1'b1, 3'd6);
        cdb(2'd2, 3'd6);
        step();
        chk("byp_valid", int'(exec_valid), 1);
        chk("byp_val", int'(exec_val), 6);
        step();
        chk("byp_empty", int'(rs_empty), 1);

        // Stall holds head outputs; flush overrides a same-cycle write
        exec_ready = 1'b0;
        wr(STR, 2'd1, 3'd4, 2'd0, 1'b1, 2'd1, 1'b1, 3'd4);
        step();
        wr(LD, 2'd2, 3'd0, 2'd0, 1'b0, 2'd2, 1'b1, 3'd0);
        step();
        wr(LD, 2'd3, 3'd0, 2'd0, 1'b0, 2'd3, 1'b1, 3'd0);
        step();
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", int'(exec_valid), 1);
            chk("stall_opcode", int'(exec_opcode), 6);
            chk("stall_val", int'(exec_val), 4);
            chk("stall_addr", int'(exec_addr), 1);
            chk("stall_rob", int'(exec_rob_idx), 1);
            step();
        end
        flush = 1'b1;
        exec_ready = 1'b1;
        wr(LD, 2'd0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 3'd0);
        sb.delete();
        step();
        chk("flush_empty", int'(rs_empty), 1);
        chk("flush_count", int'(rs_count), 0);
        chk("flush_valid", int'(exec_valid), 0);

        // Ten back-to-back alloc/issue pairs wrap the pointers twice
        for (int i = 0; i < 10; i++) begin
            wr(LD, 2'(i), 3'd0, 2'd0, 1'b0, 2'(i + 1), 1'b1, 3'd0);
            step();
            chk("wrap_count", int'(rs_count), 1);
        end
        step();
        chk("wrap_empty", int'(rs_empty), 1);

        // Asynchronous reset mid-stream
        exec_ready = 1'b0;
        wr(STR, 2'd1, 3'd3, 2'd0, 1'b1, 2'd3, 1'b0, 3'd3);
        step();
        wr(LD, 2'd2, 3'd0, 2'd0, 1'b0, 2'd2, 1'b0, 3'd0);
        step();
        chk("pre_rst_count", int'(rs_count), 2);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outs("mid_rst");
        #10 rst_n = 1'b1;
        step();
        exec_ready = 1'b1;
        wr(LD, 2'd3, 3'd0, 2'd0, 1'b0, 2'd1, 1'b1, 3'd0);
        step();
        chk("post_rst_valid", int'(exec_valid), 1);
        chk("post_rst_rob", int'(exec_rob_idx), 3);
        step();
        chk("post_rst_empty", int'(rs_empty), 1);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mem_rs_queue.md
MEM_RS_QUEUE -- requirements
Module: mem_rs_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries (power of two, >=2).
REQ-002 SHALL have parameter ROB_W, default 2, meaning ROB index width.
REQ-003 SHALL have parameter DATA_W, default 3, meaning store data width.
REQ-004 SHALL have parameter ADDR_W, default 2, meaning memory address width.
REQ-005 SHALL have ports, one per line:
 clk  input  1  clock, rising edge
 rst_n  input  1  reset, asynchronous, active-low
 flush  input  1  synchronous squash of all entries
 write_en  input  1  allocate request
 rob_idx  input  ROB_W  ROB index of new op
 opcode  input  3  3'b101 LD, 3'b110 STR
 val  input  DATA_W  store data, if val_ready
 q_val  input  ROB_W  ROB tag producing store data
 val_ready  input  1  store data valid at allocation
 addr  input  ADDR_W  memory address
 cdb_en  input  1  CDB broadcast valid
 cdb_rob_idx  input  ROB_W  CDB tag
 cdb_val  input  DATA_W  CDB data
 exec_ready  input  1  downstream memory unit accepts
 exec_valid  output  1  head entry ready to issue
 exec_opcode  output  3  head opcode
 exec_val  output  DATA_W  head store data
 exec_addr  output  ADDR_W  head address
 exec_rob_idx  output  ROB_W  head ROB index
 rs_full  output  1  count == DEPTH
 rs_empty  output  1  count == 0
 rs_count  output  clog2(DEPTH+1)  occupied entries

Function
REQ-006 SHALL store entries in a circular buffer with head/tail pointers wrapping modulo DEPTH; issue strictly in allocation order.
REQ-007 SHALL allocate at tail when write_en=1, rs_full=0 (value at cycle start) and opcode is LD or STR; otherwise write is ignored with no state change.
REQ-008 SHALL mark an LD entry ready at allocation regardless of val_ready; STR entry ready when val_ready=1.
REQ-009 SHALL, on cdb_en=1, load cdb_val and set ready in every occupied STR entry not ready whose q_val equals cdb_rob_idx.
REQ-010 SHALL bypass: STR allocated with val_ready=0 in the same cycle as a matching CDB broadcast is written ready with cdb_val.
REQ-011 SHALL drive exec_valid = !rs_empty && head entry ready; exec_* combinationally from head entry.
REQ-012 SHALL transfer on exec_valid && exec_ready at the rising edge: head advances, count decrements.
REQ-013 SHALL hold exec_* stable while exec_valid=1 and exec_ready=0.
REQ-014 SHALL never issue a younger entry while head is not ready (no bypass of memory order).
REQ-015 SHALL handle simultaneous allocate and transfer: both occur, count unchanged; when full at cycle start, allocate rejected even if transfer occurs.
REQ-016 SHALL, on flush=1, empty queue (pointers 0, count 0, all ready bits 0) at next edge, overriding same-cycle allocate, CDB and transfer; exec_valid may be 1 in flush cycle but no entry is retained.
REQ-017 SHALL keep rs_full, rs_empty, rs_count registered-state derived, consistent every cycle.

Reset
REQ-018 SHALL on rst_n=0 asynchronously clear all entries and pointers: exec_valid=0, exec_opcode=0, exec_val=0, exec_addr=0, exec_rob_idx=0, rs_empty=1, rs_full=0, rs_count=0.
REQ-019 SHALL discard in-flight entries on reset asserted mid-operation; first accepted write after release lands at index 0.

Verification
REQ-020 Allocate LD rob=1 addr=2, exec_ready=1 -> next cycle exec_valid=1, exec_opcode=101, exec_addr=2; following edge rs_empty=1.
REQ-021 STR q_val=3 val_ready=0 at head, then LD behind it -> exec_valid=0; cdb_en=1 tag=3 val=5 -> next cycle exec_valid=1, exec_val=5, exec_opcode=110; LD issues after.
REQ-022 Fill 4 entries, exec_ready=0 -> rs_full=1, rs_count=4; 5th write ignored; one transfer with concurrent write at full -> count=3, write rejected.
REQ-023 STR val_ready=0 q_val=2 written same cycle as cdb_en tag=2 val=6 -> entry ready, exec_val=6 next cycle.
REQ-024 3 entries, exec_valid=1 exec_ready=0 for 3 cycles -> exec_* unchanged; flush=1 with write_en=1 -> rs_empty=1, rs_count=0 next cycle.
REQ-025 Wrap test: 10 alloc/issue pairs over DEPTH=4 -> rob_idx order preserved; rst_n low mid-stream -> all outputs reset values immediately.
